// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: two-port write arbiter in front of a shared FIFO.
// Round-robin on ties, bounded bursts while the other port waits, and a
// single IDLE cycle between every change of owner.
// Optional per-port accepted-write counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int unsigned B     = 8,
  parameter int unsigned BURST = 4   // legal range 1..255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [B-1:0] data0,
  input  logic [B-1:0] data1,
  output logic         ack0,
  output logic         ack1,
  input  logic         fifo_full,
  output logic         fifo_wr,
  output logic [B-1:0] fifo_wr_data,
  output logic [1:0]   grant
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]  wcnt0,
  output logic [15:0]  wcnt1
`endif
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WCNT_W = 16;
  // Value of the burst counter when the write that completes a burst is accepted
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

  // Encoding doubles as the one-hot grant vector
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;   // port that most recently received a grant
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic               own_req;
  logic               other_req;

  // State, tie-break history and burst counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Next-state and same-cycle write/ack decode
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    burst_d      = burst_q;
    own_req      = 1'b0;
    other_req    = 1'b0;
    fifo_wr      = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    fifo_wr_data = '0;

    case (state_q)
      IDLE: begin
        // Port 0 wins when alone, or on a tie when port 1 was served last
        if (req0 && (!req1 || last_q)) begin
          state_d = G0;
          last_d  = 1'b0;
          burst_d = '0;
        end else if (req1) begin
          state_d = G1;
          last_d  = 1'b1;
          burst_d = '0;
        end
      end

      G0, G1: begin
        own_req      = (state_q == G1) ? req1 : req0;
        other_req    = (state_q == G1) ? req0 : req1;
        fifo_wr_data = (state_q == G1) ? data1 : data0;
        fifo_wr      = own_req & ~fifo_full;
        ack0         = fifo_wr & (state_q == G0);
        ack1         = fifo_wr & (state_q == G1);

        if (!own_req) begin
          state_d = IDLE;
        end else if (fifo_wr) begin
          if (burst_q == BURST_LAST) begin
            // Burst complete: yield only if the other port is waiting
            burst_d = '0;
            if (other_req) begin
              state_d = IDLE;
            end
          end else begin
            burst_d = burst_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant = state_q;

`ifdef FIFO_ARB_STATS_EN
  logic [WCNT_W-1:0] wcnt0_q, wcnt0_d;
  logic [WCNT_W-1:0] wcnt1_q, wcnt1_d;

  // Accepted-write counters, wrapping naturally at 16 bits
  always_comb begin
    wcnt0_d = wcnt0_q + WCNT_W'(ack0);
    wcnt1_d = wcnt1_q + WCNT_W'(ack1);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt0_q <= '0;
      wcnt1_q <= '0;
    end else begin
      wcnt0_q <= wcnt0_d;
      wcnt1_q <= wcnt1_d;
    end
  end

  assign wcnt0 = wcnt0_q;
  assign wcnt1 = wcnt1_q;
`endif

endmodule
